// File: rtl/sop_mac_pipeline.sv
// Three-stage signed sum-of-three-products (AB + CD +/- EF) with a running
// accumulator, clock-enable stall and saturation of the result to Y_W bits.
module sop_mac_pipeline #(
   parameter int A_W       = 18,
   parameter int B_W       = 8,
   parameter int C_W       = 12,
   parameter int D_W       = 8,
   parameter int E_W       = 14,
   parameter int F_W       = 19,
   parameter int Y_W       = 36,
   parameter int ACC_GUARD = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [1:0]            mode,
   input  logic signed [A_W-1:0] A,
   input  logic signed [B_W-1:0] B,
   input  logic signed [C_W-1:0] C,
   input  logic signed [D_W-1:0] D,
   input  logic signed [E_W-1:0] E,
   input  logic signed [F_W-1:0] F,
   output logic                  out_valid,
   output logic signed [Y_W-1:0] Y,
   output logic                  sat
);

   function automatic int maxOf(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   localparam int AB_W  = A_W + B_W;
   localparam int CD_W  = C_W + D_W;
   localparam int EF_W  = E_W + F_W;
   localparam int P_W   = maxOf(maxOf(AB_W, CD_W), EF_W) + 2;
   localparam int ACC_W = P_W + ACC_GUARD;
   localparam int CMP_W = maxOf(ACC_W, Y_W);

   typedef enum logic [1:0] {
      MODE_SUM  = 2'b00,
      MODE_DIFF = 2'b01,
      MODE_ACC  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   logic signed [A_W-1:0]   s1A_q;
   logic signed [B_W-1:0]   s1B_q;
   logic signed [C_W-1:0]   s1C_q;
   logic signed [D_W-1:0]   s1D_q;
   logic signed [E_W-1:0]   s1E_q;
   logic signed [F_W-1:0]   s1F_q;
   mode_e                   s1Mode_q;
   logic                    s1Valid_q;

   logic signed [AB_W-1:0]  s2Pab_q, s2Pab_d;
   logic signed [CD_W-1:0]  s2Pcd_q, s2Pcd_d;
   logic signed [EF_W-1:0]  s2Pef_q, s2Pef_d;
   mode_e                   s2Mode_q;
   logic                    s2Valid_q;

   logic signed [P_W-1:0]   sum_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, res_d;
   logic signed [CMP_W-1:0] resExt;
   logic signed [Y_W-1:0]   y_q, y_d;
   logic                    sat_q, sat_d;
   logic                    outValid_q;

   // Operands are widened to the full product width before multiplying so
   // the product is exact and carries its sign.
   always_comb begin
      s2Pab_d = AB_W'(s1A_q) * AB_W'(s1B_q);
      s2Pcd_d = CD_W'(s1C_q) * CD_W'(s1D_q);
      s2Pef_d = EF_W'(s1E_q) * EF_W'(s1F_q);
   end

   // Final stage: sum, accumulator update and clipping. The accumulator wraps
   // silently; only the value leaving the block is saturated.
   always_comb begin
      sum_d = P_W'(s2Pab_q) + P_W'(s2Pcd_q);
      if (s2Mode_q == MODE_DIFF) sum_d = sum_d - P_W'(s2Pef_q);
      else                       sum_d = sum_d + P_W'(s2Pef_q);
      acc_d = acc_q;
      res_d = ACC_W'(sum_d);
      case (s2Mode_q)
         MODE_ACC: begin
            acc_d = acc_q + ACC_W'(sum_d);
            res_d = acc_d;
         end
         MODE_LOAD: acc_d = ACC_W'(sum_d);
         default: ;
      endcase
      resExt = CMP_W'(res_d);
      // In range exactly when every bit from the Y sign bit upward agrees.
      sat_d = !((&resExt[CMP_W-1:Y_W-1]) || !(|resExt[CMP_W-1:Y_W-1]));
      if (sat_d) y_d = resExt[CMP_W-1] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
      else       y_d = resExt[Y_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1A_q      <= '0;
         s1B_q      <= '0;
         s1C_q      <= '0;
         s1D_q      <= '0;
         s1E_q      <= '0;
         s1F_q      <= '0;
         s1Mode_q   <= MODE_SUM;
         s1Valid_q  <= 1'b0;
         s2Pab_q    <= '0;
         s2Pcd_q    <= '0;
         s2Pef_q    <= '0;
         s2Mode_q   <= MODE_SUM;
         s2Valid_q  <= 1'b0;
         acc_q      <= '0;
         y_q        <= '0;
         sat_q      <= 1'b0;
         outValid_q <= 1'b0;
      end else if (ce) begin
         s1A_q      <= A;
         s1B_q      <= B;
         s1C_q      <= C;
         s1D_q      <= D;
         s1E_q      <= E;
         s1F_q      <= F;
         s1Mode_q   <= mode_e'(mode);
         s1Valid_q  <= in_valid;
         s2Pab_q    <= s2Pab_d;
         s2Pcd_q    <= s2Pcd_d;
         s2Pef_q    <= s2Pef_d;
         s2Mode_q   <= s1Mode_q;
         s2Valid_q  <= s1Valid_q;
         outValid_q <= s2Valid_q;
         // Bubbles leave the accumulator and the last result untouched.
         if (s2Valid_q) begin
            acc_q <= acc_d;
            y_q   <= y_d;
            sat_q <= sat_d;
         end
      end
   end

   assign out_valid = outValid_q;
   assign Y         = y_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_sop_mac_pipeline.sv
// Scoreboard bench for sop_mac_pipeline: a default-width instance and a
// Y_W=24 instance share operands; expected results are queued at issue time.
module tb_sop_mac_pipeline;

   typedef struct {
      longint y;
      logic   sat;
      int     due;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                ce  = 1'b1;
   logic                inValid   = 1'b0;
   logic                inValid24 = 1'b0;
   logic [1:0]          mode = 2'b00;
   logic signed [17:0]  A = '0;
   logic signed [7:0]   B = '0;
   logic signed [11:0]  C = '0;
   logic signed [7:0]   D = '0;
   logic signed [13:0]  E = '0;
   logic signed [18:0]  F = '0;
   logic                outValid, outValid24;
   logic signed [35:0]  Y;
   logic signed [23:0]  Y24;
   logic                sat, sat24;

   exp_t q[$];
   exp_t q24[$];
   int   checks = 0;
   int   errors = 0;
   int   enabledCycles = 0;
   logic advanced = 1'b0;

   sop_mac_pipeline dut (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(inValid), .mode(mode),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
      .out_valid(outValid), .Y(Y), .sat(sat)
   );

   sop_mac_pipeline #(.Y_W(24)) dut24 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(inValid24), .mode(mode),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
      .out_valid(outValid24), .Y(Y24), .sat(sat24)
   );

   always #5 clk = ~clk;

   // Track which edges actually advanced the pipe, so a held out_valid during
   // a stall is not mistaken for a fresh result.
   always @(posedge clk) begin
      advanced <= ce && !rst;
      if (ce && !rst) enabledCycles <= enabledCycles + 1;
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every fresh result from either instance.
   always @(negedge clk) begin
      exp_t e;
      if (advanced && outValid) begin
         if (q.size() == 0) checkOutput("unexpected out_valid", 1, 0);
         else begin
            e = q.pop_front();
            checkOutput("Y", Y, e.y);
            checkOutput("sat", longint'(sat), longint'(e.sat));
            checkOutput("latency", enabledCycles, e.due);
         end
      end
      if (advanced && outValid24) begin
         if (q24.size() == 0) checkOutput("unexpected out_valid24", 1, 0);
         else begin
            e = q24.pop_front();
            checkOutput("Y24", Y24, e.y);
            checkOutput("sat24", longint'(sat24), longint'(e.sat));
            checkOutput("latency24", enabledCycles, e.due);
         end
      end
   end

   // Drives one sample for one edge; in_valid stays high until idleCycles.
   task automatic applyStimulus(input bit to24, input logic [1:0] m,
                                input longint a, input longint b, input longint c,
                                input longint d, input longint e, input longint f,
                                input longint expY, input logic expSat);
      exp_t x;
      mode = m;
      A = 18'(a); B = 8'(b); C = 12'(c); D = 8'(d); E = 14'(e); F = 19'(f);
      inValid   = !to24;
      inValid24 = to24;
      x.y = expY; x.sat = expSat; x.due = enabledCycles + 3;
      if (to24) q24.push_back(x);
      else      q.push_back(x);
      @(posedge clk); #1;
   endtask

   task automatic idleCycles(input int n);
      inValid = 1'b0;
      inValid24 = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      checkOutput("reset out_valid", longint'(outValid), 0);
      checkOutput("reset Y", Y, 0);
      checkOutput("reset sat", longint'(sat), 0);
      rst = 1'b0;
      idleCycles(1);

      applyStimulus(0, 2'b00, -25687, 59, -630, 36, -3200, 68895, -222002213, 0);
      idleCycles(5);
      applyStimulus(0, 2'b01, -25687, 59, -630, 36, -3200, 68895, 218925787, 0);
      idleCycles(5);
      applyStimulus(0, 2'b00, -25687, 59, -630, 36, -3200, 68895, -222002213, 0);
      applyStimulus(0, 2'b01, -25687, 59, -630, 36, -3200, 68895, 218925787, 0);
      idleCycles(5);

      applyStimulus(0, 2'b11, -25687, 59, -630, 36, -3200, 68895, -222002213, 0);
      applyStimulus(0, 2'b10, -25687, 59, -630, 36, -3200, 68895, -444004426, 0);
      applyStimulus(0, 2'b10, -25687, 59, -630, 36, -3200, 68895, -666006639, 0);
      applyStimulus(0, 2'b00, -25687, 59, -630, 36, -3200, 68895, -222002213, 0);
      applyStimulus(0, 2'b10, 0, 0, 0, 0, 0, 0, -666006639, 0);
      idleCycles(6);
      checkOutput("bubble Y hold", Y, -666006639);
      checkOutput("bubble out_valid", longint'(outValid), 0);

      applyStimulus(1, 2'b00, -25687, 59, -630, 36, -3200, 68895, -8388608, 1);
      applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 2'b01, -25687, 59, -630, 36, -3200, 68895, 8388607, 1);
      idleCycles(5);

      // Stall with two results still in flight.
      for (int k = 1; k <= 4; k++)
         applyStimulus(0, 2'b00, 100 * k, 3, k, -2, 0, 0, 298 * k, 0);
      inValid = 1'b0;
      ce = 1'b0;
      @(negedge clk);
      repeat (5) begin
         @(posedge clk); @(negedge clk);
         checkOutput("stall out_valid", longint'(outValid), 1);
         checkOutput("stall Y", Y, 596);
      end
      ce = 1'b1;
      @(posedge clk); #1;
      idleCycles(6);

      // Reset with two results in flight plus a valid during the reset edge.
      applyStimulus(0, 2'b10, -25687, 59, -630, 36, -3200, 68895, 0, 0);
      applyStimulus(0, 2'b10, -25687, 59, -630, 36, -3200, 68895, 0, 0);
      q.delete();
      rst = 1'b1;
      inValid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      inValid = 1'b0;
      checkOutput("flush out_valid", longint'(outValid), 0);
      checkOutput("flush Y", Y, 0);
      checkOutput("flush sat", longint'(sat), 0);
      idleCycles(4);
      applyStimulus(0, 2'b10, -25687, 59, -630, 36, -3200, 68895, -222002213, 0);
      idleCycles(2);

      for (int t = 0; t < 20 && (q.size() != 0 || q24.size() != 0); t++) idleCycles(1);
      checkOutput("pending results", q.size(), 0);
      checkOutput("pending results24", q24.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sop_mac_pipeline.md
Name: sop_mac_pipeline

Overview:
Parametrised, fully pipelined signed sum-of-three-products unit with a mode select, a running accumulator, valid tagging, clock-enable stall and output saturation. It is the next generation of the team's fixed-width complex arithmetic module. It keeps the same six-operand A..F pairing, but generalises the operand and result widths and adds add/subtract/accumulate modes plus overflow reporting. It sits in the DSP datapath, feeding a downstream filter/accumulator stage.

Parameters:
A_W, 18, width of signed operand A
B_W, 8, width of signed operand B
C_W, 12, width of signed operand C
D_W, 8, width of signed operand D
E_W, 14, width of signed operand E
F_W, 19, width of signed operand F
Y_W, 36, width of signed result Y
ACC_GUARD, 8, extra accumulator bits above the internal sum width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high; overrides ce
ce  in  1  clock enable; 0 freezes every register, including valids and the accumulator
in_valid  in  1  operands and mode are valid this cycle
mode  in  2  00 sum, 01 sum-minus-EF, 10 accumulate, 11 load-accumulate
A..F  in  A_W..F_W  signed operands
out_valid  out  1  Y/sat carry a new result
Y  out  Y_W  signed saturated result
sat  out  1  result was clipped to the Y_W range; qualified by out_valid

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: Y=0, out_valid=0, sat=0, accumulator=0, all internal stage valids=0. Reset mid-operation discards in-flight data. A valid presented in the rst cycle is dropped.
- Internal widths:
  - P_W = max(A_W+B_W, C_W+D_W, E_W+F_W) + 2. Default: 33+2 = 35.
  - ACC_W = P_W + ACC_GUARD. Default: 43.
  - All arithmetic is signed, with sign extension to full width before add. No truncation inside the pipe.
- Pipeline: 3 stages when ce=1. Latency from an in_valid cycle to its out_valid is exactly 3 clk edges. Throughput is 1 result per cycle.
  - S1: register A..F, mode, in_valid.
  - S2: register the products pAB, pCD, pEF and carry mode/valid.
  - S3: compute sum and accumulator, then saturate to Y_W. Register Y, sat, out_valid.
- Sum s, computed at S3:
  - Modes 00, 10, 11: s = pAB + pCD + pEF.
  - Mode 01: s = pAB + pCD - pEF.
- S3 result r by mode (acc is the accumulator before the update):
  - 00/01: r = s; acc unchanged.
  - 10: acc <= acc + s; r = acc + s.
  - 11: acc <= s; r = s.
- Accumulator wraps modulo 2^ACC_W, with no internal saturation. The guard bits make this a documented limit, not an error.
- Saturation:
  - If r > 2^(Y_W-1)-1: Y = max, sat = 1.
  - If r < -2^(Y_W-1): Y = min, sat = 1.
  - Otherwise Y = r, sat = 0.
  - sat is evaluated per result.
- Bubbles: an S2 stage with valid=0 does not touch acc, Y or sat. out_valid is 0 for that cycle and Y holds its last value. out_valid is a one-cycle pulse per result.
- ce=0: the whole pipe freezes. out_valid keeps its current value. On resume, results appear with the same relative order and spacing, counted in enabled cycles.
- mode is sampled with its operands and travels with them. Mixed modes back-to-back are legal and are applied in order.
- Accumulate after reset starts from 0.

Test Plan:
- Mode 00 with A=-25687, B=59, C=-630, D=36, E=-3200, F=68895, in_valid for 1 cycle -> 3 cycles later out_valid=1 for 1 cycle, Y=-222002213, sat=0.
- Same operands, mode 01 -> Y=218925787, sat=0. Then apply modes 00 and 01 back-to-back -> two consecutive valid outputs, -222002213 then 218925787.
- Mode 11 with the 00 operands, then mode 10 with the same operands twice -> Y=-222002213, -444004426, -666006639. Then send a mode 00 -> Y=-222002213, and the accumulator keeps -666006639.
- Instance with Y_W=24, mode 00 operands as in the first scenario -> Y=-8388608, sat=1. All-zero operands next -> Y=0, sat=0.
- Stream 4 valid samples, drop ce for 5 cycles mid-stream, then restore -> no result lost or duplicated, and out_valid is frozen during the stall.
- Assert rst for 1 cycle while 2 results are in flight -> outputs are 0, no out_valid from the flushed data, and the accumulator is 0. A following mode 10 sample returns s alone.
